// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave byte engine.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam logic [I2C_ADDR_W-1:0] I2C_GENCALL_ADDR = 7'h00;
  localparam logic [7:0] I2C_TX_UNDERRUN_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK
  } i2c_state_t;

endpackage

// File: rtl/i2c_scl_edge.sv
// Registers the synchronized SCL and derives one-cycle rise/fall strobes.
module i2c_scl_edge (
  input  logic sample_clk,
  input  logic rstn,
  input  logic scl_i,
  output logic scl_rise,
  output logic scl_fall
);

  logic scl_q;

  // Reset to 1 so an idle (high) bus does not look like a rising edge
  always_ff @(posedge sample_clk) begin
    if (!rstn) scl_q <= 1'b1;
    else       scl_q <= scl_i;
  end

  assign scl_rise = scl_i & ~scl_q;
  assign scl_fall = ~scl_i & scl_q;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C slave engine: address match, byte shift in/out, ACK/NACK.
// Optional general-call acceptance is enabled by defining I2C_GENCALL_EN.
module i2c_slave_byte_ctrl
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic       sample_clk,
  input  logic       rstn,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic       start_det,
  input  logic       stop_det,
  output logic       sda_oe,
  output logic       busy,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_load,
  output logic       tx_underrun
);

  i2c_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic       start_q;
  logic       stop_q;
  logic       ack_ok;
  logic       phase;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_edge;
  logic       stop_edge;
  logic [7:0] shifted;
  logic [7:0] tx_next;
  logic       byte_end;

  i2c_scl_edge u_scl_edge (
    .sample_clk (sample_clk),
    .rstn       (rstn),
    .scl_i      (scl_i),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall)
  );

  assign start_edge = start_det & ~start_q;
  assign stop_edge  = stop_det & ~stop_q;
  assign shifted    = {sr[6:0], sda_i};
  assign tx_next    = tx_valid ? tx_data : I2C_TX_UNDERRUN_BYTE;
  assign byte_end   = scl_rise && (bit_cnt == 3'd7);

  function automatic logic addr_match(input logic [7:0] b);
`ifdef I2C_GENCALL_EN
    return (b[7:1] == SLAVE_ADDR) || ((b[7:1] == I2C_GENCALL_ADDR) && !b[0]);
`else
    return b[7:1] == SLAVE_ADDR;
`endif
  endfunction

  // phase marks the second half of a two-step slot: the second falling edge
  // of an ACK clock, or "8 bits already sent" while transmitting
  always_ff @(posedge sample_clk) begin
    if (!rstn) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      sr          <= 8'h00;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      ack_ok      <= 1'b0;
      phase       <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      rw          <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_load     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      start_q     <= start_det;
      stop_q      <= stop_det;
      rx_valid    <= 1'b0;
      tx_load     <= 1'b0;
      tx_underrun <= 1'b0;

      if (stop_edge) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 3'd0;
        phase   <= 1'b0;
      end else if (start_edge) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= 3'd0;
        phase   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end

          ADDR: begin
            sda_oe <= 1'b0;
            if (scl_rise) begin
              sr      <= shifted;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_end) begin
                if (addr_match(shifted)) begin
                  rw    <= shifted[0];
                  busy  <= 1'b1;
                  phase <= 1'b0;
                  state <= ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                if (rw) begin
                  sr          <= tx_next;
                  tx_load     <= 1'b1;
                  tx_underrun <= ~tx_valid;
                  state       <= TX_BYTE;
                end else begin
                  state <= RX_BYTE;
                end
              end
            end
          end

          RX_BYTE: begin
            if (scl_rise) begin
              sr      <= shifted;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_end) begin
                rx_data  <= shifted;
                rx_valid <= 1'b1;
                ack_ok   <= rx_ready;
                phase    <= 1'b0;
                state    <= RX_ACK;
              end
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= ack_ok;
                phase  <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                if (ack_ok) begin
                  state <= RX_BYTE;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end
            end
          end

          // Present the MSB while SCL is low; every fall follows a rise here
          TX_BYTE: begin
            if (scl_fall) begin
              if (phase) begin
                sda_oe <= 1'b0;
                phase  <= 1'b0;
                state  <= TX_ACK;
              end else begin
                sr     <= {sr[6:0], 1'b1};
                sda_oe <= ~sr[6];
              end
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_end) phase <= 1'b1;
            end else if (!scl_i && !phase) begin
              sda_oe <= ~sr[7];
            end
          end

          TX_ACK: begin
            sda_oe <= 1'b0;
            if (!phase) begin
              if (scl_rise) begin
                if (!sda_i) begin
                  phase <= 1'b1;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end
            end else if (scl_fall) begin
              phase       <= 1'b0;
              bit_cnt     <= 3'd0;
              sr          <= tx_next;
              tx_load     <= 1'b1;
              tx_underrun <= ~tx_valid;
              state       <= TX_BYTE;
            end
          end

          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
